clk_ctrl_bank: RTL and testbench
================================

# clk_ctrl_bank

Parametrised clock-control stage that sits directly behind the rPLL on the GW1NR-9 designs. It qualifies the PLL `lock` output with a synchroniser and a stability filter, and generates a synchronous reset for downstream logic. It also provides NUM_CH independently programmable divided tick/square-wave channels, which can be reconfigured at runtime without glitches. Slow peripheral timing, such as LCD enable strobes and Pmod bus clocks, is derived from these channels instead of from additional PLL outputs.

## Interface
- NUM_CH, 4: number of divider channels (1..8).
- DIV_W, 16: divisor width in bits.
- LOCK_FILTER, 1024: number of consecutive synchronised-lock cycles required before the clock is declared locked (≥1).
- DEFAULT_DIV, 26999: reset value of every channel divisor.
- CH_W, derived: max(1, $clog2(NUM_CH)).

Ports (clock and reset first):
- clk  in  1  system clock (PLL `clkout`).
- rst  in  1  asynchronous, active-high reset.
- pll_lock  in  1  raw PLL lock; asynchronous to clk.
- ch_en  in  NUM_CH  per-channel run enable.
- cfg_we  in  1  divisor write strobe, sampled for one cycle.
- cfg_ch  in  CH_W  channel index for the write.
- cfg_div  in  DIV_W  new divisor value.
- lost_clr  in  1  clears the sticky `lost_lock` flag.
- locked  out  1  qualified lock.
- rst_out  out  1  synchronous active-high reset for downstream logic.
- tick  out  NUM_CH  one-cycle pulse every div+1 cycles.
- sq  out  NUM_CH  square wave with period 2·(div+1).
- lost_lock  out  1  sticky flag: lock dropped while in RUN.

## Operation
- **Lock synchroniser.** `pll_lock` passes through a 2-FF synchroniser; the result is `lock_s`.
- **State machine.**
  - States: FILTER, RUN. Reset state is FILTER with filter counter = 0.
  - FILTER: counter increments while `lock_s`=1 and clears to 0 whenever `lock_s`=0.
  - FILTER→RUN: when the counter reaches LOCK_FILTER−1 with `lock_s`=1.
  - RUN→FILTER: on any cycle with `lock_s`=0.
- **Outputs by state.**
  - `locked`=1 and `rst_out`=0 only in RUN.
  - The RUN→FILTER transition sets `lost_lock`.
  - `lost_clr` clears `lost_lock`. If set and clear occur in the same cycle, set wins.
- **Divisor registers.**
  - Each channel has an active divisor `div_a` and a shadow divisor `div_s`, both reset to DEFAULT_DIV (truncated to DIV_W).
  - Writes: `cfg_we`=1 with `cfg_ch` < NUM_CH writes `div_s`. Writes with `cfg_ch` ≥ NUM_CH are ignored.
  - `div_s` is copied into `div_a` when the channel counter wraps, or immediately if the channel is idle (not RUN, or `ch_en`=0).
- **Channel counter.**
  - When not in RUN, or when `ch_en`=0: `cnt`=0, `tick`=0, `sq`=0.
  - Otherwise `cnt` counts 0..`div_a`, then wraps to 0.
  - `tick` is registered and high for the one cycle after `cnt`==`div_a`.
  - `sq` toggles on the same edge that asserts `tick`.
- **Divide ratio.** Tick period = `div_a`+1 cycles. `div_a`=0 gives `tick` held high continuously and `sq` toggling every cycle.
- **Mid-operation reset.** Asserting `rst` returns every register to its reset value immediately (asynchronously). Divisors revert to DEFAULT_DIV.

## Timing
- **Reset values:** `locked`=0, `rst_out`=1, `tick`=0, `sq`=0, `lost_lock`=0.
- **Lock-up latency:** with `pll_lock` held high from edge 0, `lock_s`=1 after edge 2. `locked` rises and `rst_out` falls after edge LOCK_FILTER+2.
- **Lock-loss latency:** a `pll_lock` drop is seen on `lock_s` 2 edges later. `locked`, `rst_out`, `tick`, `sq` and `lost_lock` all update on the next edge, 3 edges after the drop.
- **Glitch filtering:** a `lock_s` low pulse of 1 cycle during FILTER restarts the full count.
- **First tick:** the first RUN cycle (with `ch_en`=1) has `cnt`=0. The first `tick` appears `div_a`+1 cycles after `locked` rises. `ch_en` rising in RUN behaves the same relative to its own rise.
- **Divisor write while running:**
  - The new value applies from the first period after the current period completes.
  - A tick period never mixes the old and new divisors.
  - The last write before the wrap wins.
- **Simultaneous wrap and write:** a `cfg_we` in the same cycle as `cnt`==`div_a` loads the new value for the next period.

## Test plan
- **Reset and lock qualification:** `rst` pulse, then `pll_lock`=1 with LOCK_FILTER=16. Expect `locked`=1 and `rst_out`=0 exactly 18 edges after `pll_lock` rises; all outputs at reset values beforehand.
- **Lock glitch:** with LOCK_FILTER=16, `pll_lock` drops for 1 cycle at count 10 of FILTER. Expect `locked` delayed until 16 clean cycles have elapsed after the glitch; `lost_lock` stays 0.
- **Lock loss in RUN:** `pll_lock` drops. Expect `locked`=0, `rst_out`=1, `tick`/`sq`=0 and `lost_lock`=1 three edges later. `lost_clr`=1 together with a new loss event leaves `lost_lock`=1.
- **Divider ratios:**
  - ch0 div=0: `tick` held continuously high.
  - ch1 div=4: `tick` every 5 cycles, `sq` period 10.
  - ch2 disabled via `ch_en`: `cnt`, `tick` and `sq` stay 0.
- **Runtime reconfiguration:** ch1 div=4 running; write div=9 at `cnt`=2. Expect the current period still to be 5 cycles, then 10-cycle periods. A write with `cfg_ch`=NUM_CH changes no channel.
- **Asynchronous reset mid-run:** assert `rst` between clock edges. Expect `tick`, `sq` and `locked` to be 0 immediately, and divisors back to DEFAULT_DIV once the block is re-locked.

Source files
------------

// File: rtl/clk_ctrl_bank.sv
// Clock-control stage behind the PLL: lock qualification, downstream reset generation
// and a bank of glitch-free, runtime-programmable tick/square-wave dividers.
module clk_ctrl_bank #(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 16,
    parameter int LOCK_FILTER = 1024,
    parameter int DEFAULT_DIV = 26999,
    parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pll_lock,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic              lost_clr,
    output logic              locked,
    output logic              rst_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] sq,
    output logic              lost_lock
);

    localparam int FILT_W = (LOCK_FILTER > 1) ? $clog2(LOCK_FILTER) : 1;
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILTER - 1);
    localparam logic [DIV_W-1:0]  DIV_RST   = DIV_W'(DEFAULT_DIV);

    typedef enum logic {FILTER, RUN} state_t;

    state_t             state_reg;
    logic               sync1_reg;
    logic               lock_s_reg;
    logic [FILT_W-1:0]  filt_cnt_reg;
    logic               locked_reg;
    logic               rst_out_reg;
    logic               lost_lock_reg;
    logic [NUM_CH-1:0]  tick_reg;
    logic [NUM_CH-1:0]  sq_reg;
    logic               run_now;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_reg  <= 1'b0;
            lock_s_reg <= 1'b0;
        end else begin
            sync1_reg  <= pll_lock;
            lock_s_reg <= sync1_reg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= FILTER;
            filt_cnt_reg  <= '0;
            locked_reg    <= 1'b0;
            rst_out_reg   <= 1'b1;
            lost_lock_reg <= 1'b0;
        end else begin
            case (state_reg)
                FILTER: begin
                    if (lost_clr)
                        lost_lock_reg <= 1'b0;
                    if (!lock_s_reg) begin
                        filt_cnt_reg <= '0;
                    end else if (filt_cnt_reg == FILT_LAST) begin
                        state_reg    <= RUN;
                        filt_cnt_reg <= '0;
                        locked_reg   <= 1'b1;
                        rst_out_reg  <= 1'b0;
                    end else begin
                        filt_cnt_reg <= filt_cnt_reg + 1'b1;
                    end
                end
                RUN: begin
                    // A new loss takes priority over a simultaneous clear.
                    if (!lock_s_reg) begin
                        state_reg     <= FILTER;
                        locked_reg    <= 1'b0;
                        rst_out_reg   <= 1'b1;
                        lost_lock_reg <= 1'b1;
                    end else if (lost_clr) begin
                        lost_lock_reg <= 1'b0;
                    end
                end
                default: state_reg <= FILTER;
            endcase
        end
    end

    // Channels look ahead at lock_s so they stop on the same edge that drops locked.
    assign run_now = (state_reg == RUN) && lock_s_reg;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [DIV_W-1:0] div_a_reg;
            logic [DIV_W-1:0] div_s_reg;
            logic [DIV_W-1:0] cnt_reg;
            logic             wr_hit;
            logic             active;
            logic             wrap;

            assign wr_hit = cfg_we && (cfg_ch == CH_W'(gi));
            assign active = run_now && ch_en[gi];
            assign wrap   = (cnt_reg == div_a_reg);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    div_a_reg    <= DIV_RST;
                    div_s_reg    <= DIV_RST;
                    cnt_reg      <= '0;
                    tick_reg[gi] <= 1'b0;
                    sq_reg[gi]   <= 1'b0;
                end else begin
                    if (wr_hit)
                        div_s_reg <= cfg_div;
                    // Bypass the shadow so a write coinciding with the wrap still lands.
                    if (!active || wrap)
                        div_a_reg <= wr_hit ? cfg_div : div_s_reg;
                    if (!active) begin
                        cnt_reg      <= '0;
                        tick_reg[gi] <= 1'b0;
                        sq_reg[gi]   <= 1'b0;
                    end else begin
                        tick_reg[gi] <= wrap;
                        if (wrap) begin
                            cnt_reg    <= '0;
                            sq_reg[gi] <= ~sq_reg[gi];
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                end
            end
        end
    endgenerate

    assign locked    = locked_reg;
    assign rst_out   = rst_out_reg;
    assign lost_lock = lost_lock_reg;
    assign tick      = tick_reg;
    assign sq        = sq_reg;

endmodule

// File: tb/tb_clk_ctrl_bank.sv
// Directed bench for clk_ctrl_bank: lock qualification, glitch filtering, lock loss,
// divider ratios, runtime reconfiguration and asynchronous reset.
module tb_clk_ctrl_bank;

    localparam int NUM_CH = 3;
    localparam int DIV_W  = 16;
    localparam int LF     = 16;
    localparam int DDIV   = 7;
    localparam int CH_W   = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              pll_lock;
    logic [NUM_CH-1:0] ch_en;
    logic              cfg_we;
    logic [CH_W-1:0]   cfg_ch;
    logic [DIV_W-1:0]  cfg_div;
    logic              lost_clr;
    logic              locked;
    logic              rst_out;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] sq;
    logic              lost_lock;

    int tests = 0;
    int fails = 0;

    clk_ctrl_bank #(
        .NUM_CH(NUM_CH), .DIV_W(DIV_W), .LOCK_FILTER(LF), .DEFAULT_DIV(DDIV)
    ) dut (
        .clk(clk), .rst(rst), .pll_lock(pll_lock), .ch_en(ch_en),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div), .lost_clr(lost_clr),
        .locked(locked), .rst_out(rst_out), .tick(tick), .sq(sq), .lost_lock(lost_lock)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int k, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s edge=%0d actual=%0h expected=%0h", name, k, act, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; pll_lock = 1'b0; ch_en = '0; cfg_we = 1'b0;
        cfg_ch = '0; cfg_div = '0; lost_clr = 1'b0;
        step(); step();
        tests++;
        if ({locked, rst_out, tick, sq, lost_lock} !== {1'b0, 1'b1, 3'b000, 3'b000, 1'b0}) begin
            fails++;
            $display("FAIL reset_values actual=%b required=%b",
                     {locked, rst_out, tick, sq, lost_lock}, 9'b0_1_000_000_0);
        end
        rst = 1'b0;
        pll_lock = 1'b1;
        for (int k = 1; k <= LF + 2; k++) begin
            step();
            tests++;
            if ({locked, rst_out} !== ((k == LF + 2) ? 2'b10 : 2'b01)) begin
                fails++;
                $display("FAIL lockup edge=%0d locked/rst_out actual=%b required=%b",
                         k, {locked, rst_out}, (k == LF + 2) ? 2'b10 : 2'b01);
            end
        end
        $display("[TB] reset/lock-up done");
    endtask

    task automatic test_glitch();
        rst = 1'b1; pll_lock = 1'b0;
        step();
        rst = 1'b0;
        pll_lock = 1'b1;
        for (int k = 1; k <= 31; k++) begin
            step();
            if (k == 12) pll_lock = 1'b0;
            if (k == 13) pll_lock = 1'b1;
            tests++;
            if (locked !== (k >= 31)) begin
                fails++;
                $display("FAIL glitch_locked edge=%0d actual=%b required=%b", k, locked, k >= 31);
            end
        end
        tests++;
        if (lost_lock !== 1'b0) begin
            fails++;
            $display("FAIL glitch_lost_lock actual=%b required=0", lost_lock);
        end
        $display("[TB] lock glitch done");
    endtask

    task automatic test_divider();
        logic [2:0] et;
        logic [2:0] es;
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 16'd0;
        step();
        cfg_ch = 2'd1; cfg_div = 16'd4;
        step();
        cfg_we = 1'b0;
        ch_en = 3'b011;
        for (int k = 1; k <= 20; k++) begin
            step();
            et = {1'b0, (k % 5) == 0, 1'b1};
            es = {1'b0, ((k / 5) % 2) == 1, (k % 2) == 1};
            chk("div_tick", k, {5'd0, tick}, {5'd0, et});
            chk("div_sq", k, {5'd0, sq}, {5'd0, es});
        end
        $display("[TB] divider ratios done");
    endtask

    task automatic test_reconfig();
        logic [2:0] et;
        logic [2:0] es;
        for (int e = 1; e <= 46; e++) begin
            step();
            if (e == 2) begin
                cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 16'd9;
            end
            if (e == 3) begin
                cfg_ch = 2'd3; cfg_div = 16'd2;
            end
            if (e == 4) cfg_we = 1'b0;
            et = {1'b0, (e == 5) || (e > 5 && ((e - 5) % 10) == 0), 1'b1};
            es = {1'b0, (e >= 5) && (((e - 5) / 10) % 2 == 0), (e % 2) == 1};
            chk("reconf_tick", e, {5'd0, tick}, {5'd0, et});
            chk("reconf_sq", e, {5'd0, sq}, {5'd0, es});
        end
        $display("[TB] runtime reconfiguration done");
    endtask

    task automatic test_ch_en_rise();
        ch_en = 3'b111;
        for (int k = 1; k <= 17; k++) begin
            step();
            chk("en_rise_tick2", k, {7'd0, tick[2]}, {7'd0, (k == 8) || (k == 16)});
            chk("en_rise_sq2", k, {7'd0, sq[2]}, {7'd0, (k >= 8) && (k < 16)});
        end
        $display("[TB] ch_en rise done");
    endtask

    task automatic test_lock_loss();
        pll_lock = 1'b0;
        step(); step();
        chk("loss_locked_e2", 2, {7'd0, locked}, 8'd1);
        step();
        chk("loss_outputs", 3, {1'b0, locked, rst_out, tick, sq[0], lost_lock},
            {1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b1});
        chk("loss_sq", 3, {5'd0, sq}, 8'd0);
        lost_clr = 1'b1;
        step();
        lost_clr = 1'b0;
        chk("lost_clr", 1, {7'd0, lost_lock}, 8'd0);
        pll_lock = 1'b1;
        for (int k = 1; k <= LF + 2; k++) step();
        chk("relock", LF + 2, {7'd0, locked}, 8'd1);
        pll_lock = 1'b0;
        step(); step();
        lost_clr = 1'b1;
        step();
        lost_clr = 1'b0;
        chk("set_wins_over_clr", 3, {6'd0, locked, lost_lock}, 8'b01);
        $display("[TB] lock loss done");
    endtask

    task automatic test_async_reset();
        pll_lock = 1'b1;
        for (int k = 1; k <= LF + 2; k++) step();
        step(); step(); step();
        chk("pre_rst_tick0", 0, {7'd0, tick[0]}, 8'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_outputs", 0, {2'b0, locked, rst_out, tick[0], tick[1], lost_lock, 1'b0},
            {2'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        chk("async_rst_tick_sq", 0, {2'b0, tick, sq}, 8'd0);
        step();
        rst = 1'b0;
        for (int k = 1; k <= LF + 2 + 9; k++) begin
            step();
            chk("rerun_locked", k, {7'd0, locked}, {7'd0, k >= LF + 2});
            chk("rerun_default_tick", k, {5'd0, tick}, (k == LF + 2 + DDIV + 1) ? 8'd7 : 8'd0);
        end
        $display("[TB] async reset done");
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_divider();
        test_reconfig();
        test_ch_en_rise();
        test_lock_loss();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
